// File: rtl/rom_player.sv
// rom_player: steps through an asynchronous-read ROM and presents each entry
// for at least TICKS cycles. The consumer handshakes each entry with ready.
// Playback can optionally loop back to address 0 and can be aborted with stop.
module rom_player #(
  parameter int unsigned Nloc  = 16,
  parameter int unsigned Dbits = 4,
  parameter int unsigned TICKS = 4,
  localparam int unsigned AW   = $clog2(Nloc)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             loop,
  output logic [AW-1:0]    addr,
  input  logic [Dbits-1:0] rom_data,
  output logic [Dbits-1:0] data,
  output logic             valid,
  input  logic             ready,
  output logic             busy,
  output logic             done
);

  localparam int unsigned TW = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TICKS - 1);
  localparam logic [AW-1:0] ALAST = AW'(Nloc - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_SHOW,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [Dbits-1:0]  data_q, data_d;
  logic [TW-1:0]     cnt_q, cnt_d;
  logic              valid_q, busy_q, done_q;

  // State, address, data and tick counter registers; status flags follow the next state
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      valid_q <= (state_d == S_SHOW);
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
    end
  end

  // Next-state logic: fetch, show until consumed, advance/wrap/finish; stop overrides
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        addr_d = '0;
        if (start && !stop) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        data_d  = rom_data;
        cnt_d   = '0;
        state_d = S_SHOW;
      end
      S_SHOW: begin
        if (cnt_q != TLAST) begin
          cnt_d = cnt_q + TW'(1);
        end
        if (ready && (cnt_q == TLAST)) begin
          if (addr_q != ALAST) begin
            addr_d  = addr_q + AW'(1);
            state_d = S_FETCH;
          end else if (loop) begin
            addr_d  = '0;
            state_d = S_FETCH;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        addr_d  = '0;
        state_d = S_IDLE;
      end
      default: begin
        addr_d  = '0;
        state_d = S_IDLE;
      end
    endcase

    // Abort has priority over any consume or completion
    if (stop && (state_q != S_IDLE)) begin
      addr_d  = '0;
      state_d = S_IDLE;
    end
  end

  assign addr  = addr_q;
  assign data  = data_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_rom_player.sv
// Bench for rom_player: directed scenarios plus random traffic, compared each
// cycle against an entry/age playback model; a TICKS=1 instance is checked
// against a closed-form timing pattern.
module tb_rom_player;

  localparam int unsigned NLOC = 4;
  localparam int unsigned DB   = 4;
  localparam int unsigned T    = 2;
  localparam int unsigned AW   = 2;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset, start, stop, loop, ready;
  logic [AW-1:0] addr;
  logic [DB-1:0] rom_data, data;
  logic valid, busy, done;

  logic start1, stop1, loop1, ready1;
  logic [AW-1:0] addr1;
  logic [DB-1:0] rom_data1, data1;
  logic valid1, busy1, done1;

  logic [DB-1:0] mem [NLOC];
  assign rom_data  = mem[addr];
  assign rom_data1 = mem[addr1];

  rom_player #(.Nloc(NLOC), .Dbits(DB), .TICKS(T)) u0 (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .loop(loop),
    .addr(addr), .rom_data(rom_data), .data(data), .valid(valid),
    .ready(ready), .busy(busy), .done(done)
  );

  rom_player #(.Nloc(NLOC), .Dbits(DB), .TICKS(1)) u1 (
    .clock(clock), .reset(reset), .start(start1), .stop(stop1), .loop(loop1),
    .addr(addr1), .rom_data(rom_data1), .data(data1), .valid(valid1),
    .ready(ready1), .busy(busy1), .done(done1)
  );

  int checks = 0;
  int passes = 0;
  int busy_cnt = 0;
  int done_cnt = 0;

  // Playback model: active run / finishing cycle, entry index and age of entry
  // (age 0 = fetch cycle, age >= 1 = entry on display).
  bit m_act, m_fin;
  int m_pos, m_age;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_step();
    if (reset) begin
      m_act = 0; m_fin = 0; m_pos = 0; m_age = 0;
    end else if (!m_act && !m_fin) begin
      if (start && !stop) begin
        m_act = 1; m_pos = 0; m_age = 0;
      end
    end else if (stop) begin
      m_act = 0; m_fin = 0; m_pos = 0; m_age = 0;
    end else if (m_fin) begin
      m_fin = 0; m_pos = 0;
    end else if (m_age == 0) begin
      m_age = 1;
    end else if (ready && m_age >= int'(T)) begin
      if (m_pos < int'(NLOC) - 1) begin
        m_pos++; m_age = 0;
      end else if (loop) begin
        m_pos = 0; m_age = 0;
      end else begin
        m_act = 0; m_fin = 1;
      end
    end else begin
      m_age++;
    end
  endtask

  task automatic check_model();
    bit ev;
    ev = m_act && (m_age >= 1);
    chk("addr",  32'(addr),  (m_act || m_fin) ? 32'(m_pos) : 32'd0);
    chk("valid", 32'(valid), 32'(ev));
    chk("busy",  32'(busy),  32'(m_act || m_fin));
    chk("done",  32'(done),  32'(m_fin));
    if (ev) chk("data", 32'(data), 32'(mem[m_pos]));
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    check_model();
    if (busy) busy_cnt++;
    if (done) done_cnt++;
  endtask

  task automatic wait_show(input int a, input string tag);
    bit ok;
    ok = 0;
    for (int i = 0; i < 80 && !ok; i++) begin
      tick();
      if (valid && addr == AW'(a)) ok = 1;
    end
    if (!ok) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_idle(input string tag);
    bit ok;
    ok = 0;
    for (int i = 0; i < 80 && !ok; i++) begin
      tick();
      if (!busy) ok = 1;
    end
    if (!ok) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    reset = 1; start = 0; stop = 0; loop = 0; ready = 1;
    start1 = 0; stop1 = 0; loop1 = 0; ready1 = 1;
    mem[0] = 4'hA; mem[1] = 4'hB; mem[2] = 4'hC; mem[3] = 4'hD;
    m_act = 0; m_fin = 0; m_pos = 0; m_age = 0;

    // Reset state
    tick(); tick();
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_busy1", 32'(busy1), 32'd0);
    reset = 0;
    tick();

    // Full non-loop playback
    busy_cnt = 0; done_cnt = 0;
    start = 1; tick(); start = 0;
    chk("latency_fetch_valid", 32'(valid), 32'd0);
    tick();
    chk("latency_first_data", 32'(data), 32'hA);
    repeat (16) tick();
    chk("busy_cycles", 32'(busy_cnt), 32'd13);
    chk("done_pulses", 32'(done_cnt), 32'd1);

    // Back-pressure on entry B
    start = 1; tick(); start = 0;
    wait_show(1, "wait_b");
    ready = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_addr", 32'(addr), 32'd1);
      chk("stall_data", 32'(data), 32'hB);
      chk("stall_valid", 32'(valid), 32'd1);
    end
    ready = 1;
    run_idle("stall_end");

    // Looping, then stop during the second C
    done_cnt = 0;
    loop = 1; start = 1; tick(); start = 0;
    wait_show(3, "loop_d");
    wait_show(0, "loop_wrap");
    chk("wrap_data", 32'(data), 32'hA);
    wait_show(2, "loop_c2");
    stop = 1; tick(); stop = 0;
    chk("stop_addr", 32'(addr), 32'd0);
    chk("stop_valid", 32'(valid), 32'd0);
    chk("stop_busy", 32'(busy), 32'd0);
    chk("loop_no_done", 32'(done_cnt), 32'd0);
    loop = 0;
    tick();

    // Reset while showing C, then replay from A
    done_cnt = 0;
    start = 1; tick(); start = 0;
    wait_show(2, "rst_c");
    reset = 1; tick(); reset = 0;
    chk("midrst_data", 32'(data), 32'd0);
    chk("midrst_valid", 32'(valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_addr", 32'(addr), 32'd0);
    tick();
    chk("midrst_no_restart", 32'(busy), 32'd0);
    start = 1; tick(); start = 0;
    wait_show(0, "replay");
    chk("replay_data", 32'(data), 32'hA);
    run_idle("replay_end");
    chk("midrst_no_done", 32'(done_cnt), 32'd1);

    // start held while busy has no effect; start+stop in IDLE stays IDLE
    busy_cnt = 0;
    start = 1; repeat (10) tick(); start = 0;
    run_idle("restart_ign");
    chk("restart_busy_cycles", 32'(busy_cnt), 32'd13);
    start = 1; stop = 1; tick(); tick();
    chk("startstop_idle", 32'(busy), 32'd0);
    start = 0; stop = 0; tick();

    // Random traffic; ROM contents only change while the player is idle
    for (int i = 0; i < 600; i++) begin
      ready = ($urandom_range(0, 3) != 0);
      loop  = $urandom_range(0, 1) != 0;
      start = ($urandom_range(0, 5) == 0);
      stop  = ($urandom_range(0, 39) == 0);
      reset = ($urandom_range(0, 99) == 0);
      if (!m_act && !m_fin && !busy && $urandom_range(0, 3) == 0)
        for (int k = 0; k < int'(NLOC); k++) mem[k] = DB'($urandom);
      tick();
    end
    reset = 0; start = 0; stop = 0; loop = 0; ready = 1;
    run_idle("rand_end");
    tick();

    // TICKS=1 instance: one valid cycle per entry, period of two
    mem[0] = 4'h1; mem[1] = 4'h2; mem[2] = 4'h3; mem[3] = 4'h4;
    start1 = 1;
    for (int j = 1; j <= 11; j++) begin
      tick();
      start1 = 0;
      chk("t1_valid", 32'(valid1), 32'((j >= 2) && (j <= 8) && (j % 2 == 0)));
      chk("t1_done",  32'(done1),  32'(j == 9));
      chk("t1_busy",  32'(busy1),  32'((j >= 1) && (j <= 9)));
      if ((j >= 2) && (j <= 8) && (j % 2 == 0))
        chk("t1_data", 32'(data1), 32'(mem[(j - 2) / 2]));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
